// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter (double dabble), one adjust-and-shift
// step per clock. A start/done handshake frames each conversion; the result
// and overflow flag are held between done pulses.
module bin2bcd_seq_ctrl #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     bin_in,
  output logic             busy,
  output logic             done,
  output logic [4*D-1:0]   bcd_out,
  output logic             ovf
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;

  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_bin;
  logic [4*D-1:0] r_acc;
  logic           r_ovf;
  logic [4*D-1:0] r_bcd;
  logic           r_ovf_out;

  logic [4*D-1:0] w_adj;
  logic [4*D-1:0] w_acc_nxt;
  logic           w_shout;
  logic           w_accept;
  logic           w_last;

  // Add 3 to every digit >= 5 so the following shift carries correctly
  // into the next decimal digit.
  function automatic logic [4*D-1:0] dabble_adjust(input logic [4*D-1:0] acc);
    logic [4*D-1:0] res;
    res = acc;
    for (int k = 0; k < D; k++) begin
      if (acc[4*k +: 4] >= 4'd5) begin
        res[4*k +: 4] = acc[4*k +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

  // Step datapath: adjusted accumulator shifted left with the binary MSB
  // entering digit 0; the bit leaving the top digit marks overflow.
  always_comb begin
    w_adj     = dabble_adjust(r_acc);
    w_shout   = w_adj[4*D-1];
    w_acc_nxt = {w_adj[4*D-2:0], r_bin[W-1]};
    w_accept  = start && (r_state != S_CONV);
    w_last    = (r_cnt == CW'(1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a request in DONE restarts immediately.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_CONV;
      S_CONV: if (w_last) w_next = S_DONE;
      S_DONE: w_next = start ? S_CONV : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, per-step shift/count, and result latch on the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin     <= '0;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_ovf_out <= 1'b0;
    end else if (w_accept) begin
      r_bin <= bin_in;
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_cnt <= CW'(W);
    end else if (r_state == S_CONV) begin
      r_bin <= {r_bin[W-2:0], 1'b0};
      r_acc <= w_acc_nxt;
      r_ovf <= r_ovf | w_shout;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_bcd     <= w_acc_nxt;
        r_ovf_out <= r_ovf | w_shout;
      end
    end
  end

  assign busy    = (r_state == S_CONV);
  assign done    = (r_state == S_DONE);
  assign bcd_out = r_bcd;
  assign ovf     = r_ovf_out;

endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// Bench for bin2bcd_seq_ctrl: three configurations (W8/D3, W5/D2, W8/D2)
// checked every cycle against an arithmetic model, plus directed cases.
module tb_bin2bcd_seq_ctrl;

  logic clk;
  logic rst;
  logic       st [3];
  logic [7:0] bn [3];

  logic        o0_busy, o0_done, o0_ovf;
  logic [11:0] o0_bcd;
  logic        o1_busy, o1_done, o1_ovf;
  logic [7:0]  o1_bcd;
  logic        o2_busy, o2_done, o2_ovf;
  logic [7:0]  o2_bcd;

  logic        busy_a [3];
  logic        done_a [3];
  logic        ovf_a  [3];
  logic [15:0] bcd_a  [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int wid [3] = '{8, 5, 8};
  int dig [3] = '{3, 2, 2};
  int p10 [3] = '{1000, 100, 100};

  // model state: ph 0 = idle, 1..W = converting, W+1 = done cycle
  int   ph  [3] = '{0, 0, 0};
  int   val [3] = '{0, 0, 0};
  int   eb  [3] = '{0, 0, 0};
  logic eo  [3] = '{1'b0, 1'b0, 1'b0};

  bin2bcd_seq_ctrl #(.W(8), .D(3)) u_w8d3 (
    .clk(clk), .rst(rst), .start(st[0]), .bin_in(bn[0]),
    .busy(o0_busy), .done(o0_done), .bcd_out(o0_bcd), .ovf(o0_ovf));
  bin2bcd_seq_ctrl #(.W(5), .D(2)) u_w5d2 (
    .clk(clk), .rst(rst), .start(st[1]), .bin_in(bn[1][4:0]),
    .busy(o1_busy), .done(o1_done), .bcd_out(o1_bcd), .ovf(o1_ovf));
  bin2bcd_seq_ctrl #(.W(8), .D(2)) u_w8d2 (
    .clk(clk), .rst(rst), .start(st[2]), .bin_in(bn[2]),
    .busy(o2_busy), .done(o2_done), .bcd_out(o2_bcd), .ovf(o2_ovf));

  assign busy_a[0] = o0_busy;  assign done_a[0] = o0_done;
  assign ovf_a[0]  = o0_ovf;   assign bcd_a[0]  = {4'b0, o0_bcd};
  assign busy_a[1] = o1_busy;  assign done_a[1] = o1_done;
  assign ovf_a[1]  = o1_ovf;   assign bcd_a[1]  = {8'b0, o1_bcd};
  assign busy_a[2] = o2_busy;  assign done_a[2] = o2_done;
  assign ovf_a[2]  = o2_ovf;   assign bcd_a[2]  = {8'b0, o2_bcd};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int to_bcd(input int v, input int d);
    int r;
    int x;
    r = 0;
    x = v;
    for (int k = 0; k < d; k++) begin
      r = r | ((x % 10) << (4 * k));
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int i, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[inst %0d] cycle %0d: got %0h expected %0h", nm, i, cyc, act, exp);
    end
  endtask

  // Reference model advanced on each clock edge from the sampled inputs.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      int nph;
      int nv;
      int neb;
      logic neo;
      nph = ph[i]; nv = val[i]; neb = eb[i]; neo = eo[i];
      if (rst) begin
        nph = 0; neb = 0; neo = 1'b0;
      end else if (ph[i] >= 1 && ph[i] <= wid[i]) begin
        nph = ph[i] + 1;
        if (nph == wid[i] + 1) begin
          neb = to_bcd(val[i] % p10[i], dig[i]);
          neo = (val[i] >= p10[i]);
        end
      end else if (st[i]) begin
        nph = 1;
        nv  = int'(bn[i]) & ((1 << wid[i]) - 1);
      end else begin
        nph = 0;
      end
      ph[i] <= nph; val[i] <= nv; eb[i] <= neb; eo[i] <= neo;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 3; i++) begin
        chk("busy", i, busy_a[i], (ph[i] >= 1 && ph[i] <= wid[i]));
        chk("done", i, done_a[i], (ph[i] == wid[i] + 1));
        chk("bcd",  i, bcd_a[i], eb[i]);
        chk("ovf",  i, ovf_a[i], eo[i]);
      end
    end
  end

  task automatic convert(input int i, input int b, input int exp_bcd, input logic exp_ovf);
    int n;
    st[i] = 1'b1;
    bn[i] = 8'(b);
    @(negedge clk);
    st[i] = 1'b0;
    bn[i] = 8'($urandom);
    n = 1;
    while (!done_a[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", i, n, wid[i] + 1);
    chk("lit_bcd", i, bcd_a[i], exp_bcd);
    chk("lit_ovf", i, ovf_a[i], exp_ovf);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      bn[i] = 8'd0;
    end

    // model pins
    chk("pin_19", 0, to_bcd(19, 3), 'h019);
    chk("pin_255", 2, to_bcd(255 % 100, 2), 'h55);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 0, o0_busy, 0);
    chk("rst_done", 0, o0_done, 0);
    chk("rst_bcd", 0, o0_bcd, 0);
    chk("rst_ovf", 0, o0_ovf, 0);

    // first conversion with exact busy/done window
    st[0] = 1'b1;
    bn[0] = 8'd19;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) begin
        st[0] = 1'b0;
        bn[0] = 8'd0;
      end
      chk("win_busy", 0, o0_busy, (k <= 8));
      chk("win_done", 0, o0_done, (k == 9));
    end
    chk("lit_19", 0, o0_bcd, 'h019);
    chk("lit_19ovf", 0, o0_ovf, 0);
    @(negedge clk);
    chk("done_once", 0, o0_done, 0);
    chk("hold_19", 0, o0_bcd, 'h019);

    convert(0, 255, 'h255, 1'b0);
    convert(0, 0, 'h000, 1'b0);
    convert(0, 100, 'h100, 1'b0);

    // W=8, D=2 overflow then clean result
    convert(2, 255, 'h55, 1'b1);
    convert(2, 99, 'h99, 1'b0);

    // start during conversion is ignored, bin_in changes ignored
    @(negedge clk);
    st[0] = 1'b1; bn[0] = 8'd200;
    @(negedge clk); st[0] = 1'b0;
    @(negedge clk);
    @(negedge clk); st[0] = 1'b1; bn[0] = 8'd7;
    @(negedge clk); st[0] = 1'b0; bn[0] = 8'd99;
    n = 4;
    while (!o0_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ign_latency", 0, n, 9);
    chk("ign_bcd", 0, o0_bcd, 'h200);

    // reset in cycle 4 of a conversion
    @(negedge clk);
    st[0] = 1'b1; bn[0] = 8'd123;
    @(negedge clk); st[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mid_rst_busy", 0, o0_busy, 0);
    chk("mid_rst_done", 0, o0_done, 0);
    chk("mid_rst_bcd", 0, o0_bcd, 0);
    chk("mid_rst_ovf", 0, o0_ovf, 0);
    convert(0, 42, 'h042, 1'b0);

    // W=5 back-to-back sweep with start held high
    @(negedge clk);
    st[1] = 1'b1;
    bn[1] = 8'd0;
    for (int i = 0; i < 20; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!o1_done && n < 20);
      chk("sweep_gap", 1, n, 6);
      chk("sweep_bcd", 1, o1_bcd, (i / 10) * 16 + (i % 10));
      chk("sweep_ovf", 1, o1_ovf, 0);
      bn[1] = 8'(i + 1);
      if (i == 19) st[1] = 1'b0;
    end

    // randomized traffic on all three instances
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        st[i] = ($urandom_range(0, 2) == 0);
        bn[i] = (i == 1) ? 8'($urandom_range(0, 31)) : 8'($urandom);
      end
    end
    for (int i = 0; i < 3; i++) st[i] = 1'b0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq_ctrl.md
Name: bin2bcd_seq_ctrl

Overview:
Sequential binary-to-BCD converter controller built on the double-dabble algorithm. It replaces the wide combinational converter path when operands are wider than a few bits. A request/done handshake sequences one adjust-and-shift step per clock over a shared shift register. It sits between a binary producer (counter, ALU result) and a BCD/7-segment display consumer.

Parameters:
W, 8, binary operand width in bits (W >= 2)
D, 3, number of BCD output digits (output width 4*D)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  synchronous active-high reset
start  input  1  conversion request, sampled on rising clk edge
bin_in  input  W  binary operand, captured on accepted start
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bcd_out/ovf are valid
bcd_out  output  4*D  packed BCD result, digit 0 in bits [3:0]
ovf  output  1  result exceeded 10^D-1 (valid with done, held until next done)

Behaviour:
- One clock domain, clk only. rst is synchronous and active-high. On rst: state=IDLE, busy=0, done=0, bcd_out=0, ovf=0, internal shift/count registers=0. rst overrides everything, including mid-conversion; no partial result appears.
- FSM states: IDLE, CONV, DONE.
- IDLE: on an edge with start=1:
  - capture bin_in into the binary shift register
  - clear the BCD accumulator and the internal overflow flag
  - load the step counter with W
  - go to CONV; busy=1 from the next cycle.
- CONV, one step per edge:
  - combinationally add 3 to every accumulator digit >= 5
  - shift {accumulator, binary reg} left by 1; the binary MSB enters digit 0 bit 0
  - if the bit shifted out of the top digit (digit D-1 bit 3) is 1, set the internal overflow flag (sticky)
  - decrement the counter; when the counter reaches 0 on this edge, go to DONE.
- DONE, lasts exactly one cycle:
  - done=1, busy=0
  - bcd_out and ovf are loaded from the accumulator and flag on the edge entering DONE, so they are valid while done=1
  - next state is IDLE, or CONV if start=1 on this edge (back-to-back request, captured exactly as in IDLE).
- Latency: start accepted at edge 0. busy=1 for cycles 1..W. done=1 in cycle W+1. Back-to-back throughput is one result per W+1 cycles.
- start while in CONV is ignored: no queuing, no effect on the result.
- bin_in is sampled only on the accepted start edge; later changes do not affect the result.
- bcd_out/ovf hold their last value between done pulses.
- If ovf=1, bcd_out holds the low D digits of the true value. Digits never exceed 9 when ovf=0.
- No internal state besides the FSM, counter (ceil(log2(W+1)) bits), binary shift register (W), accumulator (4*D), and overflow flag.

Test Plan:
- W=8, D=3: rst then start with bin_in=8'd19 -> busy high cycles 1-8; done=1 in cycle 9 only; bcd_out=12'h019, ovf=0.
- W=8, D=3: bin_in=255 -> bcd_out=12'h255. bin_in=0 -> bcd_out=12'h000. bin_in=100 -> 12'h100. ovf=0 in all cases.
- W=5, D=2: sweep bin_in 0..19 back-to-back, start held high -> done every 6 cycles; bcd_out=8'h00..8'h19 in order; no gaps.
- W=8, D=2: bin_in=255 -> ovf=1, bcd_out=8'h55. Then bin_in=99 -> ovf=0, bcd_out=8'h99.
- W=8, D=3: start with 200; pulse start with 7 and change bin_in during cycle 3 -> ignored; result 12'h200 at cycle 9.
- Assert rst in cycle 4 of a conversion -> next cycle busy=0, done=0, bcd_out=0, ovf=0, state IDLE. A fresh start with 42 then yields 12'h042 after 9 cycles.
